fifobram_source_fifo: RTL



---
 rtl/fifobram_source_fifo_pkg.sv | 13 +
 rtl/fifobram_interface.sv | 41 ++++
 rtl/fifobram_source_fifo_sdp_bram.sv | 36 +++
 rtl/fifobram_source_fifo.sv | 112 +++++++++++
 4 files changed

// File: rtl/fifobram_source_fifo_pkg.sv
// Shared constants for the BRAM-backed FIFO and its interface.
package fifobram_source_fifo_pkg;

    localparam int FIFO_WIDTH            = 32;
    localparam int FIFO_LOG2_DEPTH       = 5;
    localparam int FIFO_ALMOSTFULL_SLACK = 4;

    // Count at which almostfull asserts for a given depth and slack.
    function automatic int af_threshold(input int log2_depth, input int slack);
        return (2 ** log2_depth) - slack;
    endfunction

endpackage

// File: rtl/fifobram_interface.sv
// Producer/consumer/source view of a BRAM FIFO.
// Overflow/underflow exist only with FIFOBRAM_SOURCE_ERRCHECK_EN.
interface fifobram_interface
    import fifobram_source_fifo_pkg::*;
#(
    parameter int WIDTH      = FIFO_WIDTH,
    parameter int LOG2_DEPTH = FIFO_LOG2_DEPTH
);

    logic                  we;
    logic [WIDTH-1:0]      wdata;
    logic                  re;
    logic [WIDTH-1:0]      rdata;
    logic                  rvalid;
    logic                  almostfull;
    logic                  empty;
    logic [LOG2_DEPTH-1:0] count;
`ifdef FIFOBRAM_SOURCE_ERRCHECK_EN
    logic                  overflow;
    logic                  underflow;
`endif

    modport fifo_source (
        input  we, wdata, re,
        output rdata, rvalid, almostfull, empty, count
`ifdef FIFOBRAM_SOURCE_ERRCHECK_EN
        , output overflow, underflow
`endif
    );

    modport fifo_write (
        output we, wdata,
        input  almostfull, count
    );

    modport fifo_read (
        output re,
        input  rdata, rvalid, empty, count
    );

endinterface

// File: rtl/fifobram_source_fifo_sdp_bram.sv
// Simple dual-port RAM: one write port, one registered read port.
module pipearch_sdp_bram #(
    parameter int WIDTH      = 32,
    parameter int LOG2_DEPTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [LOG2_DEPTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [LOG2_DEPTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [2**LOG2_DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the output register is reset; the array never is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fifobram_source_fifo.sv
// BRAM-backed synchronous FIFO, source end of fifobram_interface.
// Optional sticky error flags: define FIFOBRAM_SOURCE_ERRCHECK_EN.
module fifobram_source_fifo
    import fifobram_source_fifo_pkg::*;
#(
    parameter int WIDTH            = FIFO_WIDTH,
    parameter int LOG2_DEPTH       = FIFO_LOG2_DEPTH,
    parameter int ALMOSTFULL_SLACK = FIFO_ALMOSTFULL_SLACK
) (
    input  logic                    clk,
    input  logic                    reset,
    fifobram_interface.fifo_source  fifo
);

    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam logic [LOG2_DEPTH-1:0] FULL_CNT = LOG2_DEPTH'(DEPTH - 1);
    localparam logic [LOG2_DEPTH:0] AF_CNT =
        (LOG2_DEPTH + 1)'(af_threshold(LOG2_DEPTH, ALMOSTFULL_SLACK));

    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_DEPTH-1:0] r_rd_ptr;
    logic [LOG2_DEPTH-1:0] r_count;
    logic                  r_rvalid;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [WIDTH-1:0] w_rdata;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = fifo.we && !w_full;
    assign w_rd_acc = fifo.re && !w_empty;

    pipearch_sdp_bram #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_bram (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (fifo.wdata),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Flags decode registered count only: no path from we/re.
    assign fifo.rdata      = w_rdata;
    assign fifo.rvalid     = r_rvalid;
    assign fifo.count      = r_count;
    assign fifo.empty      = w_empty;
    assign fifo.almostfull = ({1'b0, r_count} >= AF_CNT);

`ifdef FIFOBRAM_SOURCE_ERRCHECK_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (fifo.we && w_full) begin
                r_overflow <= 1'b1;
            end
            if (fifo.re && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign fifo.overflow  = r_overflow;
    assign fifo.underflow = r_underflow;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(fifo.we && w_full))
                else $warning("fifo overflow: write dropped");
            assert (!(fifo.re && w_empty))
                else $warning("fifo underflow: read ignored");
        end
    end
`endif
`endif

endmodule
